// File: rtl/srm_pkg.sv
// ---------------------------------------------------------------------------
// srm_pkg
// Shared definitions for the Simple RISC Machine controller slice.
//   - opcode / op field encodings
//   - controller state codes
//   - mem_cmd codes (MNONE / MREAD / MWRITE)
//   - vsel codes (VSEL_C / VSEL_PC / VSEL_IMM / VSEL_MDATA)
//   - small decode helpers shared by the controller
// ---------------------------------------------------------------------------
package srm_pkg;

  // Instruction class encodings held in instr[15:13]
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // Sub-operation encodings held in instr[12:11]
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  // Controller states, kept as plain constants so older tools and
  // netlist viewers see a fixed binary code for every state
  typedef logic [4:0] state_t;
  localparam state_t S_RST       = 5'd0;
  localparam state_t S_IF1       = 5'd1;
  localparam state_t S_IF2       = 5'd2;
  localparam state_t S_UPD_PC    = 5'd3;
  localparam state_t S_DECODE    = 5'd4;
  localparam state_t S_GET_A     = 5'd5;
  localparam state_t S_GET_B     = 5'd6;
  localparam state_t S_EXEC      = 5'd7;
  localparam state_t S_WR_REG    = 5'd8;
  localparam state_t S_WR_IMM    = 5'd9;
  localparam state_t S_ADDR_CALC = 5'd10;
  localparam state_t S_LD_ADDR   = 5'd11;
  localparam state_t S_MEM_RD    = 5'd12;
  localparam state_t S_MEM_WB    = 5'd13;
  localparam state_t S_ST_B      = 5'd14;
  localparam state_t S_ST_C      = 5'd15;
  localparam state_t S_MEM_WR    = 5'd16;
  localparam state_t S_HALT      = 5'd17;

  // Memory command codes
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // Register-file write-data source select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // CMP only updates status flags, never a register
  function automatic logic is_cmp(input logic [2:0] opc, input logic [1:0] o);
    return (opc == OPC_ALU) && (o == OP_CMP);
  endfunction

  // Instructions whose ALU pass must ignore the A operand
  function automatic logic uses_zero_a(input logic [2:0] opc, input logic [1:0] o);
    return ((opc == OPC_MOV) && (o == OP_MOV_REG)) ||
           ((opc == OPC_ALU) && (o == OP_MVN));
  endfunction

endpackage

// File: rtl/srm_instr_dec.sv
// ---------------------------------------------------------------------------
// srm_instr_dec
// Purely combinational field extraction from the instruction register.
// Ports:
//   instr   in   W   current IR contents
//   opcode  out  3   instr[15:13]
//   op      out  2   instr[12:11]
//   rn      out  3   instr[10:8]
//   rd      out  3   instr[7:5]
//   sh      out  2   instr[4:3]
//   rm      out  3   instr[2:0]
//   sximm5  out  W   instr[4:0] sign-extended
//   sximm8  out  W   instr[7:0] sign-extended
// ---------------------------------------------------------------------------
module srm_instr_dec #(
  parameter int W = 16
) (
  input  logic [W-1:0] instr,
  output logic [2:0]   opcode,
  output logic [1:0]   op,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [1:0]   sh,
  output logic [2:0]   rm,
  output logic [W-1:0] sximm5,
  output logic [W-1:0] sximm8
);

  // Fixed field positions of the 16-bit instruction format
  assign opcode = instr[15:13];
  assign op     = instr[12:11];
  assign rn     = instr[10:8];
  assign rd     = instr[7:5];
  assign sh     = instr[4:3];
  assign rm     = instr[2:0];

  // Immediates replicate their top bit out to the full datapath width
  assign sximm5 = {{(W-5){instr[4]}}, instr[4:0]};
  assign sximm8 = {{(W-8){instr[7]}}, instr[7:0]};

endmodule

// File: rtl/srm_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// srm_ctrl_fsm
// Moore controller sequencing the Simple RISC Machine datapath through
// fetch, PC update, decode, operand read, ALU, writeback and LDR/STR
// memory access. Every output is a decode of the current state plus instr.
//
// Build option:
//   SRM_MEM_STALL_EN  when defined, IF1 / MEM_RD / MEM_WR wait for mem_ready;
//                     otherwise memory is fixed 1-cycle latency and
//                     mem_ready is ignored.
//
// Ports:
//   clk        in   1     system clock, rising edge
//   reset      in   1     asynchronous, active-high
//   instr      in   W     current IR contents
//   mem_ready  in   1     memory handshake (stall build only)
//   load_ir    out  1     IR load strobe
//   load_pc    out  1     PC load strobe
//   reset_pc   out  1     selects 0 as next PC
//   addr_sel   out  1     1 = PC drives memory address, 0 = data-address reg
//   load_addr  out  1     data-address register load
//   mem_cmd    out  2     00 none, 01 read, 10 write
//   vsel       out  2     register write source (C / PC / sximm8 / mdata)
//   asel       out  1     force ALU A operand to zero
//   bsel       out  1     select sximm5 as ALU B operand
//   ALUop      out  2     ALU operation
//   shift      out  2     B-operand shifter control
//   loada/loadb/loadc/loads/write  out 1 each  datapath register strobes
//   readnum    out  3     register file read port
//   writenum   out  3     register file write port
//   sximm8     out  W     sign-extended instr[7:0]
//   sximm5     out  W     sign-extended instr[4:0]
//   halted     out  1     high in HALT
// ---------------------------------------------------------------------------
module srm_ctrl_fsm
  import srm_pkg::*;
#(
  parameter int PC_W = 9,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] instr,
  input  logic         mem_ready,
  output logic         load_ir,
  output logic         load_pc,
  output logic         reset_pc,
  output logic         addr_sel,
  output logic         load_addr,
  output logic [1:0]   mem_cmd,
  output logic [1:0]   vsel,
  output logic         asel,
  output logic         bsel,
  output logic [1:0]   ALUop,
  output logic [1:0]   shift,
  output logic         loada,
  output logic         loadb,
  output logic         loadc,
  output logic         loads,
  output logic         write,
  output logic [2:0]   readnum,
  output logic [2:0]   writenum,
  output logic [W-1:0] sximm8,
  output logic [W-1:0] sximm5,
  output logic         halted
);

  // The PC width belongs to the datapath; it is carried here so both
  // blocks are instantiated from the same parameter set
  localparam int unused_pc_w = PC_W;

  state_t       state;
  state_t       state_nxt;
  logic         mem_go;
  logic [2:0]   opcode;
  logic [1:0]   op;
  logic [2:0]   rn;
  logic [2:0]   rd;
  logic [1:0]   sh;
  logic [2:0]   rm;
  logic [W-1:0] dec_sximm5;
  logic [W-1:0] dec_sximm8;

  srm_instr_dec #(.W(W)) u_dec (
    .instr  (instr),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm5 (dec_sximm5),
    .sximm8 (dec_sximm8)
  );

  // Memory-facing states either wait on the handshake or assume the
  // access always completes in one cycle
`ifdef SRM_MEM_STALL_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go           = 1'b1;
`endif

  // State register; reset is asynchronous so strobes drop the moment
  // reset rises, before any further write can complete
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Unsupported encodings fall back to IF1 so they
  // behave as NOPs; unknown state codes recover through RST
  always_comb begin
    state_nxt = S_RST;
    case (state)
      S_RST:       state_nxt = S_IF1;
      S_IF1:       state_nxt = mem_go ? S_IF2 : S_IF1;
      S_IF2:       state_nxt = S_UPD_PC;
      S_UPD_PC:    state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = S_IF1;
        if ((opcode == OPC_MOV) && (op == OP_MOV_IMM)) begin
          state_nxt = S_WR_IMM;
        end else if ((opcode == OPC_MOV) && (op == OP_MOV_REG)) begin
          state_nxt = S_GET_B;
        end else if (opcode == OPC_ALU) begin
          state_nxt = S_GET_A;
        end else if (((opcode == OPC_LDR) || (opcode == OPC_STR)) && (op == OP_MEM)) begin
          state_nxt = S_GET_A;
        end else if (opcode == OPC_HALT) begin
          state_nxt = S_HALT;
        end
      end
      S_GET_A:     state_nxt = (opcode == OPC_ALU) ? S_GET_B : S_ADDR_CALC;
      S_GET_B:     state_nxt = S_EXEC;
      S_EXEC:      state_nxt = is_cmp(opcode, op) ? S_IF1 : S_WR_REG;
      S_WR_REG:    state_nxt = S_IF1;
      S_WR_IMM:    state_nxt = S_IF1;
      S_ADDR_CALC: state_nxt = S_LD_ADDR;
      S_LD_ADDR:   state_nxt = (opcode == OPC_STR) ? S_ST_B : S_MEM_RD;
      S_MEM_RD:    state_nxt = mem_go ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    state_nxt = S_IF1;
      S_ST_B:      state_nxt = S_ST_C;
      S_ST_C:      state_nxt = S_MEM_WR;
      S_MEM_WR:    state_nxt = mem_go ? S_IF1 : S_MEM_WR;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_RST;
    endcase
  end

  // Output decode. Everything starts from the quiet default and each
  // state switches on only its own strobes. RST additionally clears the
  // instruction-derived outputs so the whole port is 0 apart from the
  // PC reset pair
  always_comb begin
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b1;
    load_addr = 1'b0;
    mem_cmd   = MNONE;
    vsel      = VSEL_C;
    asel      = 1'b0;
    bsel      = 1'b0;
    ALUop     = op;
    shift     = sh;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    readnum   = 3'd0;
    writenum  = 3'd0;
    sximm8    = dec_sximm8;
    sximm5    = dec_sximm5;
    halted    = 1'b0;
    case (state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        addr_sel = 1'b0;
        ALUop    = 2'b00;
        shift    = 2'b00;
        sximm8   = '0;
        sximm5   = '0;
      end
      S_IF1: begin
        mem_cmd = MREAD;
      end
      S_IF2: begin
        mem_cmd = MREAD;
        load_ir = 1'b1;
      end
      S_UPD_PC: begin
        load_pc = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        loadc = 1'b1;
        loads = is_cmp(opcode, op);
        asel  = uses_zero_a(opcode, op);
        if (opcode == OPC_MOV) begin
          ALUop = OP_ADD;
        end
      end
      S_WR_REG: begin
        vsel     = VSEL_C;
        writenum = rd;
        write    = 1'b1;
      end
      S_WR_IMM: begin
        vsel     = VSEL_IMM;
        writenum = rn;
        write    = 1'b1;
      end
      S_ADDR_CALC: begin
        bsel  = 1'b1;
        ALUop = OP_ADD;
        loadc = 1'b1;
      end
      S_LD_ADDR: begin
        load_addr = 1'b1;
      end
      S_MEM_RD: begin
        addr_sel = 1'b0;
        mem_cmd  = MREAD;
      end
      S_MEM_WB: begin
        addr_sel = 1'b0;
        mem_cmd  = MREAD;
        vsel     = VSEL_MDATA;
        writenum = rd;
        write    = 1'b1;
      end
      S_ST_B: begin
        readnum = rd;
        loadb   = 1'b1;
        shift   = 2'b00;
      end
      S_ST_C: begin
        asel  = 1'b1;
        ALUop = OP_ADD;
        loadc = 1'b1;
      end
      S_MEM_WR: begin
        addr_sel = 1'b0;
        mem_cmd  = MWRITE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
